// File: rtl/sib_pkg.sv
`default_nettype none
// ---- sib_pkg: shared types and default sizes for the sample-in-ball datapath ----
// ---- rev 1.0 -------------------------------------------------------------------
package sib_pkg;

  localparam int SIB_NUM_SAMPLERS_DEF = 4;
  localparam int SIB_SAMPLE_W_DEF     = 8;
  localparam int SIB_RATE_W_DEF       = 1088;

  typedef enum logic [1:0] {
    STRM_IDLE   = 2'd0,
    STRM_FILL   = 2'd1,
    STRM_STREAM = 2'd2
  } strm_fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/sib_stream_buf.sv
`default_nettype none
// ---- sib_stream_buf: one rate-block register with a full flag (ping or pong half) ----
// ---- rev 1.0 ------------------------------------------------------------------------
module sib_stream_buf
  import sib_pkg::*;
#(
  parameter int WIDTH = SIB_RATE_W_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_release,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // Release only drops the flag; contents are wiped on clear so nothing stale survives a stop.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_release) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/sib_squeeze_streamer.sv
`default_nettype none
// ---- sib_squeeze_streamer: ping-pong buffers SHAKE256 rate blocks and streams ----
// ---- them one word (NS bytes) per cycle to the SIB controller. rev 1.0        ----
module sib_squeeze_streamer
  import sib_pkg::*;
#(
  parameter int SIB_NUM_SAMPLERS = SIB_NUM_SAMPLERS_DEF,
  parameter int SIB_SAMPLE_W     = SIB_SAMPLE_W_DEF,
  parameter int SIB_RATE_W       = SIB_RATE_W_DEF
) (
  input  logic                                          clk,
  input  logic                                          rst_b,
  input  logic                                          zeroize,
  input  logic                                          start_i,
  input  logic                                          stop_i,
  output logic                                          squeeze_req_o,
  input  logic                                          squeeze_valid_i,
  input  logic [SIB_RATE_W-1:0]                         squeeze_data_i,
  output logic                                          data_valid_o,
  input  logic                                          data_hold_i,
  output logic [SIB_NUM_SAMPLERS-1:0][SIB_SAMPLE_W-1:0] data_o,
  output logic                                          busy_o
);

  localparam int SIB_WORD_W        = SIB_NUM_SAMPLERS * SIB_SAMPLE_W;
  localparam int SIB_WORDS_PER_BLK = SIB_RATE_W / SIB_WORD_W;
  localparam int CNT_W             = $clog2(SIB_WORDS_PER_BLK);

  strm_fsm_state_e r_state;
  logic            r_wr_sel;
  logic            r_rd_sel;
  logic [CNT_W-1:0] r_word_cnt;

  logic [SIB_RATE_W-1:0] w_buf_data [2];
  logic [1:0]            w_full;
  logic                  w_clear;
  logic                  w_xfer;
  logic                  w_adv;
  logic                  w_last;
  logic [SIB_WORDS_PER_BLK-1:0][SIB_WORD_W-1:0] w_blk;
  logic [SIB_WORD_W-1:0] w_word;

  assign w_clear = zeroize | stop_i;

  assign squeeze_req_o = (r_state != STRM_IDLE) & ~w_full[r_wr_sel];
  assign data_valid_o  = (r_state == STRM_STREAM) & w_full[r_rd_sel];
  assign busy_o        = (r_state != STRM_IDLE);

  // A squeeze beat coincident with stop/zeroize is dropped even though req is high.
  assign w_xfer = squeeze_req_o & squeeze_valid_i & ~w_clear;
  assign w_adv  = data_valid_o & ~data_hold_i & ~w_clear;
  assign w_last = w_adv & (r_word_cnt == CNT_W'(SIB_WORDS_PER_BLK - 1));

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      sib_stream_buf #(
        .WIDTH (SIB_RATE_W)
      ) u_buf (
        .clk       (clk),
        .rst_b     (rst_b),
        .i_clear   (w_clear),
        .i_load    (w_xfer & (r_wr_sel == 1'(gi))),
        .i_release (w_last & (r_rd_sel == 1'(gi))),
        .i_data    (squeeze_data_i),
        .o_data    (w_buf_data[gi]),
        .o_full    (w_full[gi])
      );
    end
  endgenerate

  assign w_blk  = w_buf_data[r_rd_sel];
  assign w_word = w_blk[r_word_cnt];
  assign data_o = data_valid_o ? w_word : '0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= STRM_IDLE;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_word_cnt <= '0;
    end else if (w_clear) begin
      r_state    <= STRM_IDLE;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        STRM_IDLE:   if (start_i) r_state <= STRM_FILL;
        STRM_FILL:   if (w_xfer)  r_state <= STRM_STREAM;
        STRM_STREAM: r_state <= STRM_STREAM;
        default:     r_state <= STRM_IDLE;
      endcase
      if (w_xfer) r_wr_sel <= ~r_wr_sel;
      if (w_last) begin
        r_rd_sel   <= ~r_rd_sel;
        r_word_cnt <= '0;
      end else if (w_adv) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sib_squeeze_streamer.sv
`default_nettype none
// ---- tb_sib_squeeze_streamer: directed vectors with hand-computed words ----
// ---- rev 1.0 ------------------------------------------------------------
module tb_sib_squeeze_streamer;

  localparam int NS     = 4;
  localparam int SW     = 8;
  localparam int RATE_W = 1088;

  logic clk;
  logic rst_b;
  logic zeroize;
  logic start_i;
  logic stop_i;
  logic squeeze_req_o;
  logic squeeze_valid_i;
  logic [RATE_W-1:0] squeeze_data_i;
  logic data_valid_o;
  logic data_hold_i;
  logic [NS-1:0][SW-1:0] data_o;
  logic busy_o;

  int total;
  int bad;

  sib_squeeze_streamer #(
    .SIB_NUM_SAMPLERS (NS),
    .SIB_SAMPLE_W     (SW),
    .SIB_RATE_W       (RATE_W)
  ) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .zeroize         (zeroize),
    .start_i         (start_i),
    .stop_i          (stop_i),
    .squeeze_req_o   (squeeze_req_o),
    .squeeze_valid_i (squeeze_valid_i),
    .squeeze_data_i  (squeeze_data_i),
    .data_valid_o    (data_valid_o),
    .data_hold_i     (data_hold_i),
    .data_o          (data_o),
    .busy_o          (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block with seed s: byte j = (j + s) mod 256.
  function automatic logic [RATE_W-1:0] mk_blk(input logic [7:0] seed);
    logic [RATE_W-1:0] b;
    b = '0;
    for (int j = 0; j < RATE_W / 8; j++) b[j*8 +: 8] = 8'(j) + seed;
    return b;
  endfunction

  function automatic logic [31:0] exp_word(input logic [7:0] seed, input int k);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[i*8 +: 8] = 8'(4 * k + i) + seed;
    return w;
  endfunction

  task automatic chk(input string nm, input logic er, input logic ev, input logic eb,
                     input logic [7:0] seed, input int k);
    logic [31:0] ed;
    ed = ev ? exp_word(seed, k) : 32'h0;
    total++;
    if (squeeze_req_o !== er) begin
      bad++;
      $display("FAIL %s req got=%0b exp=%0b", nm, squeeze_req_o, er);
    end
    total++;
    if (data_valid_o !== ev) begin
      bad++;
      $display("FAIL %s valid got=%0b exp=%0b", nm, data_valid_o, ev);
    end
    total++;
    if (busy_o !== eb) begin
      bad++;
      $display("FAIL %s busy got=%0b exp=%0b", nm, busy_o, eb);
    end
    total++;
    if (data_o !== ed) begin
      bad++;
      $display("FAIL %s data got=%h exp=%h", nm, data_o, ed);
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic sv, input logic [7:0] sd,
                      input logic h, input logic z);
    start_i         = st;
    stop_i          = sp;
    squeeze_valid_i = sv;
    squeeze_data_i  = sv ? mk_blk(sd) : '0;
    data_hold_i     = h;
    zeroize         = z;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       st;
    logic       sp;
    logic       sv;
    logic [7:0] sd;
    logic       h;
    logic       er;
    logic       ev;
    logic       eb;
    logic [7:0] eseed;
    int         ek;
  } vec_t;

  vec_t tbl[7];

  initial begin
    total = 0;
    bad   = 0;
    // inputs applied this cycle / outputs expected in the same cycle
    tbl[0] = '{st:0, sp:0, sv:0, sd:8'h00, h:0, er:0, ev:0, eb:0, eseed:8'h00, ek:0};
    tbl[1] = '{st:1, sp:0, sv:0, sd:8'h00, h:0, er:0, ev:0, eb:0, eseed:8'h00, ek:0};
    tbl[2] = '{st:0, sp:0, sv:1, sd:8'h00, h:0, er:1, ev:0, eb:1, eseed:8'h00, ek:0};
    tbl[3] = '{st:0, sp:0, sv:0, sd:8'h00, h:0, er:1, ev:1, eb:1, eseed:8'h00, ek:0};
    tbl[4] = '{st:0, sp:0, sv:0, sd:8'h00, h:1, er:1, ev:1, eb:1, eseed:8'h00, ek:1};
    tbl[5] = '{st:0, sp:0, sv:0, sd:8'h00, h:0, er:1, ev:1, eb:1, eseed:8'h00, ek:1};
    tbl[6] = '{st:0, sp:0, sv:0, sd:8'h00, h:0, er:1, ev:1, eb:1, eseed:8'h00, ek:2};

    rst_b = 1'b0;
    zeroize = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    squeeze_valid_i = 1'b0; squeeze_data_i = '0; data_hold_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // single block, start-up and first words
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("tbl%0d", i), tbl[i].er, tbl[i].ev, tbl[i].eb, tbl[i].eseed, tbl[i].ek);
      step(tbl[i].st, tbl[i].sp, tbl[i].sv, tbl[i].sd, tbl[i].h, 0);
    end
    for (int k = 3; k < 34; k++) begin
      if (k == 7) begin
        for (int r = 0; r < 5; r++) begin
          chk("hold_w7", 1, 1, 1, 8'h00, 7);
          step(0, 0, 0, 8'h00, 1, 0);
        end
      end
      chk($sformatf("blk0_w%0d", k), 1, 1, 1, 8'h00, k);
      step(0, 0, 0, 8'h00, 0, 0);
    end
    chk("drained", 1, 0, 1, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1, 0);
    chk("hold_no_valid", 1, 0, 1, 8'h00, 0);

    // back-to-back blocks 0x40, 0x80, third block 0xC0 offered while both full
    step(0, 0, 1, 8'h40, 0, 0);
    chk("b40_w0", 1, 1, 1, 8'h40, 0);
    step(0, 0, 1, 8'h80, 0, 0);
    for (int k = 1; k < 34; k++) begin
      chk($sformatf("b40_w%0d", k), 0, 1, 1, 8'h40, k);
      step(0, 0, 1, 8'hC0, 0, 0);
    end
    chk("b80_w0", 1, 1, 1, 8'h80, 0);
    step(0, 0, 1, 8'hC0, 0, 0);
    for (int k = 1; k < 34; k++) begin
      chk($sformatf("b80_w%0d", k), 0, 1, 1, 8'h80, k);
      step(0, 0, 0, 8'h00, 0, 0);
    end
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("bC0_w%0d", k), 1, 1, 1, 8'hC0, k);
      step(0, 0, 0, 8'h00, 0, 0);
    end

    // stop at word 20 with a coincident squeeze beat
    chk("bC0_w20", 1, 1, 1, 8'hC0, 20);
    step(0, 1, 1, 8'h11, 0, 0);
    chk("after_stop", 0, 0, 0, 8'h00, 0);
    step(1, 1, 0, 8'h00, 0, 0);
    chk("stop_beats_start", 0, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    chk("refill_empty", 1, 0, 1, 8'h00, 0);
    step(0, 0, 1, 8'h22, 0, 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("b22_w%0d", k), 1, 1, 1, 8'h22, k);
      step(0, 0, 0, 8'h00, 0, 0);
    end

    // zeroize mid-stream, also beating a simultaneous start
    chk("b22_w5", 1, 1, 1, 8'h22, 5);
    step(1, 0, 0, 8'h00, 0, 1);
    chk("after_zeroize", 0, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    chk("zfill", 1, 0, 1, 8'h00, 0);
    step(0, 0, 1, 8'h33, 0, 0);
    chk("b33_w0", 1, 1, 1, 8'h33, 0);
    step(0, 0, 0, 8'h00, 0, 0);
    chk("b33_w1", 1, 1, 1, 8'h33, 1);

    // asynchronous reset mid-stream
    #2;
    rst_b = 1'b0;
    #1;
    chk("async_rst", 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst", 0, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    step(0, 0, 1, 8'h55, 0, 0);
    chk("b55_w0", 1, 1, 1, 8'h55, 0);
    step(0, 0, 0, 8'h00, 0, 0);
    chk("b55_w1", 1, 1, 1, 8'h55, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
